// File: rtl/alu_seq_p.sv
`default_nettype none
// ==========================================================================
// alu_seq_p : handshake-driven multi-cycle ALU, registered result and flags.
// Optional multiplier / restoring divider guarded by ALU_MULDIV_EN.  Rev 1.0
// ==========================================================================
module alu_seq_p #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             wire_clock,
    input  logic             wire_reset,
    input  logic             start,
    input  logic [5:0]       opCode,
    input  logic [WIDTH-1:0] m3,
    input  logic [WIDTH-1:0] m4,
    input  logic [15:0]      FR_in,
    input  logic             useCarry,
    input  logic             dec,
    input  logic [2:0]       flagToShifthAndRot,
    output logic [WIDTH-1:0] m2,
    output logic [15:0]      FR_out,
    output logic             busy,
    output logic             done
);
    localparam logic [5:0] OP_ADD   = 6'b100000;
    localparam logic [5:0] OP_SUB   = 6'b100001;
    localparam logic [5:0] OP_MUL   = 6'b100010;
    localparam logic [5:0] OP_DIV   = 6'b100011;
    localparam logic [5:0] OP_INC   = 6'b100100;
    localparam logic [5:0] OP_MOD   = 6'b100101;
    localparam logic [5:0] OP_CMP   = 6'b010110;
    localparam logic [5:0] OP_AND   = 6'b010010;
    localparam logic [5:0] OP_OR    = 6'b010011;
    localparam logic [5:0] OP_XOR   = 6'b010100;
    localparam logic [5:0] OP_NOT   = 6'b010101;
    localparam logic [5:0] OP_SHIFT = 6'b010000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [15:0]      fr_q, fr_d;
    logic             usec_q, usec_d, dec_q, dec_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] m2_q, m2_d;
    logic [15:0]      fro_q, fro_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] res_w;
    logic [15:0]      flags_w;
    logic [SHW-1:0]   shamt_w;
    logic [SHW:0]     rot_back_w;
    logic [WIDTH-1:0] fill_l_w, fill_r_w;
    logic [WIDTH:0]   add_w, sub_w;

`ifdef ALU_MULDIV_EN
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]     div_sh_w, div_diff_w;
`endif

    // Result/flag datapath, evaluated from the captured operands in S_FIN
    always_comb begin
        shamt_w    = b_q[SHW-1:0];
        rot_back_w = (SHW+1)'(WIDTH) - {1'b0, shamt_w};
        fill_l_w   = ~({WIDTH{1'b1}} << shamt_w);
        fill_r_w   = ~({WIDTH{1'b1}} >> shamt_w);
        add_w      = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, usec_q & fr_q[11]};
        sub_w      = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, usec_q & fr_q[11]};
        res_w      = m2_q;
        flags_w    = fr_q;
        case (op_q)
            OP_ADD: begin
                res_w       = add_w[WIDTH-1:0];
                flags_w[11] = add_w[WIDTH];
                flags_w[12] = (add_w[WIDTH-1:0] == '0);
            end
            OP_SUB: begin
                res_w       = sub_w[WIDTH-1:0];
                flags_w[6]  = sub_w[WIDTH];
                flags_w[12] = (sub_w[WIDTH-1:0] == '0);
            end
            OP_INC: res_w = dec_q ? (a_q - 1'b1) : (a_q + 1'b1);
            OP_CMP: begin
                if (a_q == b_q)     flags_w[15:13] = 3'b100;
                else if (a_q < b_q) flags_w[15:13] = 3'b010;
                else                flags_w[15:13] = 3'b001;
            end
            OP_AND: begin res_w = a_q & b_q; flags_w[12] = ((a_q & b_q) == '0); end
            OP_OR:  begin res_w = a_q | b_q; flags_w[12] = ((a_q | b_q) == '0); end
            OP_XOR: begin res_w = a_q ^ b_q; flags_w[12] = ((a_q ^ b_q) == '0); end
            OP_NOT: begin res_w = ~a_q;      flags_w[12] = (~a_q == '0);        end
            OP_SHIFT: begin
                case (mode_q)
                    3'b000:        res_w = a_q << shamt_w;
                    3'b001:        res_w = (a_q << shamt_w) | fill_l_w;
                    3'b010:        res_w = a_q >> shamt_w;
                    3'b011:        res_w = (a_q >> shamt_w) | fill_r_w;
                    3'b100, 3'b101: res_w = (a_q << shamt_w) | (a_q >> rot_back_w);
                    default:       res_w = (a_q >> shamt_w) | (a_q << rot_back_w);
                endcase
            end
`ifdef ALU_MULDIV_EN
            OP_MUL: begin
                res_w       = prod_q[WIDTH-1:0];
                flags_w[10] = (prod_q[2*WIDTH-1:WIDTH] != '0);
                flags_w[12] = (prod_q[WIDTH-1:0] == '0);
            end
            OP_DIV, OP_MOD: begin
                if (b_q == '0) begin
                    res_w      = '0;
                    flags_w[9] = 1'b1;
                end else begin
                    res_w      = (op_q == OP_DIV) ? quo_q : rem_q;
                    flags_w[9] = 1'b0;
                end
                flags_w[12] = (res_w == '0);
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        fr_d    = fr_q;
        usec_d  = usec_q;
        dec_d   = dec_q;
        mode_d  = mode_q;
        m2_d    = m2_q;
        fro_d   = fro_q;
        done_d  = 1'b0;
`ifdef ALU_MULDIV_EN
        prod_d     = prod_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        div_sh_w   = {rem_q, quo_q[WIDTH-1]};
        div_diff_w = div_sh_w - {1'b0, b_q};
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = opCode;
                    a_d     = m3;
                    b_d     = m4;
                    fr_d    = FR_in;
                    usec_d  = useCarry;
                    dec_d   = dec;
                    mode_d  = flagToShifthAndRot;
                    state_d = S_FIN;
`ifdef ALU_MULDIV_EN
                    if (opCode == OP_MUL) begin
                        state_d = S_MUL;
                    end else if ((opCode == OP_DIV || opCode == OP_MOD) && (m4 != '0)) begin
                        state_d = S_DIV;
                        rem_d   = '0;
                        quo_d   = m3;
                        cnt_d   = '0;
                    end
`endif
                end
            end
`ifdef ALU_MULDIV_EN
            S_MUL: begin
                prod_d  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
                state_d = S_FIN;
            end
            // One restoring step per cycle: dividend bits shift in MSB first
            S_DIV: begin
                if (!div_diff_w[WIDTH]) begin
                    rem_d = div_diff_w[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = div_sh_w[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH-1)) state_d = S_FIN;
            end
`endif
            S_FIN: begin
                m2_d    = res_w;
                fro_d   = flags_w;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wire_clock) begin
        if (wire_reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            fr_q    <= '0;
            usec_q  <= 1'b0;
            dec_q   <= 1'b0;
            mode_q  <= '0;
            m2_q    <= '0;
            fro_q   <= '0;
            done_q  <= 1'b0;
`ifdef ALU_MULDIV_EN
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fr_q    <= fr_d;
            usec_q  <= usec_d;
            dec_q   <= dec_d;
            mode_q  <= mode_d;
            m2_q    <= m2_d;
            fro_q   <= fro_d;
            done_q  <= done_d;
`ifdef ALU_MULDIV_EN
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign m2     = m2_q;
    assign FR_out = fro_q;
    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_p.sv
`default_nettype none
// tb_alu_seq_p: directed + randomized scoreboard bench for alu_seq_p (WIDTH=16)
// against a behavioural ALU model; honours ALU_MULDIV_EN like the design.
module tb_alu_seq_p;
    localparam int W = 16;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [5:0]    opCode = '0;
    logic [W-1:0]  m3 = '0, m4 = '0;
    logic [15:0]   FR_in = '0;
    logic          useCarry = 1'b0, dec = 1'b0;
    logic [2:0]    mode = '0;
    logic [W-1:0]  m2;
    logic [15:0]   FR_out;
    logic          busy, done;

    alu_seq_p dut (
        .wire_clock(clk), .wire_reset(rst), .start(start), .opCode(opCode),
        .m3(m3), .m4(m4), .FR_in(FR_in), .useCarry(useCarry), .dec(dec),
        .flagToShifthAndRot(mode), .m2(m2), .FR_out(FR_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] m2;
        logic [15:0] fr;
        int          d;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_tests = 0, n_fail = 0;
    bit          mon_en = 1'b0;
    int          cur_k = 0, cur_d = 0, free_edge = 0;
    logic [15:0] ref_m2 = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural ALU: plain arithmetic on the captured operands.
    function automatic void model(input logic [5:0] op, input logic [15:0] a, b, fr,
                                  input bit uc, dc, input logic [2:0] md,
                                  inout logic [15:0] r, output logic [15:0] f, output int lat);
        longint      s;
        logic [15:0] v;
        bit          cin;
        f   = fr;
        lat = 1;
        cin = uc && fr[11];
        case (op)
            6'b100000: begin
                s = longint'(a) + longint'(b) + longint'(cin);
                r = 16'(s % 65536); f[11] = (s >= 65536); f[12] = (r == 0);
            end
            6'b100001: begin
                s = longint'(a) - longint'(b) - longint'(cin);
                f[6] = (s < 0);
                if (s < 0) s = s + 65536;
                r = 16'(s); f[12] = (r == 0);
            end
`ifdef ALU_MULDIV_EN
            6'b100010: begin
                s = longint'(a) * longint'(b);
                r = 16'(s % 65536); f[10] = ((s / 65536) != 0); f[12] = (r == 0); lat = 2;
            end
            6'b100011, 6'b100101: begin
                if (b == 0) begin
                    r = 0; f[9] = 1'b1; f[12] = 1'b1;
                end else begin
                    r = (op == 6'b100011) ? a / b : a % b;
                    f[9] = 1'b0; f[12] = (r == 0); lat = W + 1;
                end
            end
`endif
            6'b100100: begin
                s = longint'(a) + (dc ? -1 : 1);
                r = 16'((s + 65536) % 65536);
            end
            6'b010110: f[15:13] = (a == b) ? 3'b100 : (a < b) ? 3'b010 : 3'b001;
            6'b010010: begin r = a & b; f[12] = (r == 0); end
            6'b010011: begin r = a | b; f[12] = (r == 0); end
            6'b010100: begin r = a ^ b; f[12] = (r == 0); end
            6'b010101: begin r = ~a;    f[12] = (r == 0); end
            6'b010000: begin
                v = a;
                for (int i = 0; i < int'(b[3:0]); i++) begin
                    case (md)
                        3'b000:         v = {v[14:0], 1'b0};
                        3'b001:         v = {v[14:0], 1'b1};
                        3'b010:         v = {1'b0, v[15:1]};
                        3'b011:         v = {1'b1, v[15:1]};
                        3'b100, 3'b101: v = {v[14:0], v[15]};
                        default:        v = {v[0], v[15:1]};
                    endcase
                end
                r = v;
            end
            default: ;
        endcase
    endfunction

    // Called at a negedge: presents a request; if the model says the DUT
    // will be idle at the next edge, the expected response is queued.
    task automatic drive(input logic [5:0] op, input logic [15:0] a, b, fr,
                         input bit uc, dc, input logic [2:0] md);
        exp_t        e;
        int          lat;
        logic [15:0] f;
        start = 1'b1; opCode = op; m3 = a; m4 = b; FR_in = fr;
        useCarry = uc; dec = dc; mode = md;
        if (cyc + 1 >= free_edge) begin
            model(op, a, b, fr, uc, dc, md, ref_m2, f, lat);
            e.m2 = ref_m2; e.fr = f; e.d = cyc + 1 + lat;
            sb.push_back(e);
            cur_k = cyc + 1; cur_d = e.d; free_edge = e.d + 1;
        end
    endtask

    task automatic scramble();
        start = 1'b0; opCode = 6'($urandom); m3 = 16'($urandom); m4 = 16'($urandom);
        FR_in = 16'($urandom); useCarry = 1'($urandom); dec = 1'($urandom); mode = 3'($urandom);
    endtask

    task automatic wait_idle();
        while (cyc + 1 < free_edge) @(negedge clk);
    endtask

    task automatic run1(input logic [5:0] op, input logic [15:0] a, b, fr,
                        input bit uc, dc, input logic [2:0] md);
        wait_idle();
        drive(op, a, b, fr, uc, dc, md);
        @(negedge clk);
        scramble();
    endtask

    // Monitor: busy window, done strobes and their payload/latency
    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", 32'(busy), 32'(cyc >= cur_k && cyc < cur_d));
            if (done) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL done_unexpected: done=1 required 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("m2", 32'(m2), 32'(mon_e.m2));
                    chk("FR_out", 32'(FR_out), 32'(mon_e.fr));
                    chk("done_cycle", cyc, mon_e.d);
                end
            end else if (sb.size() > 0 && cyc >= sb[0].d) begin
                n_tests++; n_fail++;
                $display("FAIL done_missing: done=0 required 1 (cycle %0d)", cyc);
                mon_e = sb.pop_front();
            end
        end
    end

    logic [5:0] ops [14] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100101,
                            6'b100100, 6'b010110, 6'b010010, 6'b010011, 6'b010100,
                            6'b010101, 6'b010000, 6'b000110, 6'b111011};

    initial begin
        logic [5:0]  op, ab_op;
        logic [15:0] b;
        int          ab_lat, rd, k;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_m2", 32'(m2), 0);
        chk("reset_FR_out", 32'(FR_out), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        free_edge = cyc + 1;
        mon_en = 1'b1;

        run1(6'b100000, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 3'b000);
        run1(6'b100001, 16'h0003, 16'h0005, 16'h0800, 1'b1, 1'b0, 3'b000);
        run1(6'b100011, 16'h0064, 16'h0007, 16'h0000, 1'b0, 1'b0, 3'b000);
        run1(6'b100101, 16'h0064, 16'h0007, 16'h0000, 1'b0, 1'b0, 3'b000);
        run1(6'b100011, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000);
        run1(6'b100010, 16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0, 3'b000);
        run1(6'b010000, 16'h8001, 16'h0001, 16'h0000, 1'b0, 1'b0, 3'b100);
        run1(6'b010000, 16'h8001, 16'h0001, 16'h0000, 1'b0, 1'b0, 3'b110);
        run1(6'b010000, 16'h0000, 16'h0004, 16'h0000, 1'b0, 1'b0, 3'b011);
        run1(6'b010110, 16'h0005, 16'h0009, 16'h00FF, 1'b0, 1'b0, 3'b000);
        run1(6'b100100, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 3'b000);

        // Random traffic; start is often held high so back-to-back and
        // ignored-while-busy requests both occur.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                op = ops[$urandom_range(0, 13)];
                b  = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
                drive(op, 16'($urandom), b, 16'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
            end else begin
                scramble();
            end
            @(negedge clk);
        end
        scramble();
        wait_idle();
        @(negedge clk);

        // Reset mid-operation: aborts with no done, outputs return to 0
`ifdef ALU_MULDIV_EN
        ab_op = 6'b100011; ab_lat = W + 1;
`else
        ab_op = 6'b100000; ab_lat = 1;
`endif
        rd = (ab_lat > 4) ? 4 : ab_lat - 1;
        start = 1'b1; opCode = ab_op; m3 = 16'h0064; m4 = 16'h0007; FR_in = 16'h0000;
        k = cyc + 1;
        cur_k = k; cur_d = k + rd + 1; free_edge = cur_d + 1;
        @(negedge clk);
        scramble();
        repeat (rd) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ref_m2 = '0;
        chk("abort_m2", 32'(m2), 0);
        chk("abort_FR_out", 32'(FR_out), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);

        run1(6'b010011, 16'h00F0, 16'h0F00, 16'h0000, 1'b0, 1'b0, 3'b000);
        scramble();
        wait_idle();
        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
